// File: rtl/nonce_tx.sv
// Nonce transmitter: pops 32-bit nonces from a FWFT buffer and streams them
// MSB byte first over a valid/ready byte interface, counting completed nonces.
module nonce_tx #(
    parameter int unsigned COUNTBITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bufEmpty,
    input  logic [31:0]          bufData,
    output logic                 bufRdEn,
    output logic [7:0]           outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 outLast,
    output logic [COUNTBITS-1:0] sentCount,
    output logic                 busy
);

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state, state_nx;
    logic [NONCE_W-1:0]   hold, hold_nx;
    logic [IDX_W-1:0]     idx, idx_nx;
    logic [COUNTBITS-1:0] count_nx;
    logic [BYTE_W-1:0]    data_nx;
    logic                 valid_nx;
    logic                 last_nx;
    logic                 xfer;
    logic                 final_xfer;

    // Byte idx of the nonce, MSB byte first.
    function automatic logic [BYTE_W-1:0] sel_byte(input logic [NONCE_W-1:0] w,
                                                   input logic [IDX_W-1:0] i);
        logic [BYTE_W-1:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // State and datapath registers; outputs are registered copies of next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            idx       <= '0;
            sentCount <= '0;
            outData   <= '0;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            idx       <= idx_nx;
            sentCount <= count_nx;
            outData   <= data_nx;
            outValid  <= valid_nx;
            outLast   <= last_nx;
            busy      <= valid_nx;
        end
    end

    // Next-state, pop strobe and next output values.
    always_comb begin
        state_nx   = state;
        hold_nx    = hold;
        idx_nx     = idx;
        count_nx   = sentCount;
        bufRdEn    = 1'b0;
        xfer       = (state == SEND) && outReady;
        final_xfer = xfer && (idx == IDX_W'(3));

        case (state)
            IDLE: begin
                if (!bufEmpty) begin
                    bufRdEn  = 1'b1;
                    hold_nx  = bufData;
                    idx_nx   = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (final_xfer) begin
                    count_nx = sentCount + COUNTBITS'(1);
                    if (!bufEmpty) begin
                        bufRdEn = 1'b1;
                        hold_nx = bufData;
                        idx_nx  = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (xfer) begin
                    idx_nx = idx + IDX_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // Reset must hold the pop strobe low even before the flops settle.
        if (rst) begin
            bufRdEn = 1'b0;
        end

        valid_nx = (state_nx == SEND);
        data_nx  = valid_nx ? sel_byte(hold_nx, idx_nx) : BYTE_W'(0);
        last_nx  = valid_nx && (idx_nx == IDX_W'(3));
    end

endmodule

// File: tb/tb_nonce_tx.sv
// Randomized self-checking bench for nonce_tx against a byte-queue reference model.
module tb_nonce_tx;

    localparam int unsigned CB = 2;

    logic          clk;
    logic          rst;
    logic          buf_empty;
    logic [31:0]   buf_data;
    logic          buf_rd_en;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CB-1:0] sent_count;
    logic          busy;

    nonce_tx #(.COUNTBITS(CB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bufEmpty (buf_empty),
        .bufData  (buf_data),
        .bufRdEn  (buf_rd_en),
        .outData  (out_data),
        .outValid (out_valid),
        .outReady (out_ready),
        .outLast  (out_last),
        .sentCount(sent_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: source buffer contents, bytes of the nonce in flight, nonces done.
    logic [31:0] src[$];
    logic [7:0]  rem[$];
    int unsigned sent = 0;
    bit          gate_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_rden"},  32'(buf_rd_en), 32'd0);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input logic rdy);
        logic       exp_valid;
        logic       exp_pop;
        logic [7:0] exp_data;
        logic [31:0] w;
        @(negedge clk);
        out_ready = rdy;
        buf_empty = !(src.size() > 0 && gate_en);
        buf_data  = (src.size() > 0) ? src[0] : $urandom;
        #1;
        exp_valid = rem.size() > 0;
        exp_data  = exp_valid ? rem[0] : 8'h00;
        exp_pop   = !buf_empty && (rem.size() == 0 || (rem.size() == 1 && rdy));
        check("valid", 32'(out_valid),  32'(exp_valid));
        check("data",  32'(out_data),   32'(exp_data));
        check("last",  32'(out_last),   32'(rem.size() == 1));
        check("busy",  32'(busy),       32'(exp_valid));
        check("count", 32'(sent_count), 32'(sent % (1 << CB)));
        check("rden",  32'(buf_rd_en),  32'(exp_pop));
        if (exp_valid && rdy) begin
            void'(rem.pop_front());
            if (rem.size() == 0) sent++;
        end
        if (exp_pop) begin
            w = src.pop_front();
            for (int k = 3; k >= 0; k--) rem.push_back(w[8*k +: 8]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        buf_empty = 1'b1;
        buf_data  = '0;
        out_ready = 1'b0;
        #1;
        check_idle_outputs("reset");
        check("reset_count", 32'(sent_count), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Empty buffer after reset: nothing may happen.
        repeat (20) step(1'b1);

        // Single nonce, then two back-to-back nonces.
        src.push_back(32'hDEADBEEF);
        repeat (7) step(1'b1);
        src.push_back(32'h01020304);
        src.push_back(32'hA0B0C0D0);
        repeat (11) step(1'b1);

        // Five-cycle stall on the third byte.
        src.push_back(32'h11223344);
        repeat (3) step(1'b1);
        repeat (5) step(1'b0);
        repeat (3) step(1'b1);

        // Reset asserted between edges while a nonce is half sent.
        src.push_back(32'hCAFEF00D);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        check("midrst_count", 32'(sent_count), 32'd0);
        rem.delete();
        src.delete();
        sent = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) step(1'b1);

        // Random traffic: buffer gaps, backpressure, counter wrap.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0 && src.size() < 6) src.push_back($urandom);
            gate_en = ($urandom_range(0, 4) != 0);
            step($urandom_range(0, 3) != 0);
        end
        gate_en = 1'b1;
        repeat (40) step(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
